// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if
// Command and result handshake channels of the ALU issue controller.
//   cmd_valid/cmd_ready : command offer / FIFO can accept
//   cmd_op, cmd_a, cmd_b, cmd_cin, cmd_use_acc, cmd_wr_acc : command payload
//   res_valid/res_ready : result available / consumer accepts
//   res_w, res_zero, res_neg : captured result and flags
// master: command producer and result consumer. slave: the issue controller.
interface alu_issue_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int OP_W   = 3
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic              cmd_cin;
    logic              cmd_use_acc;
    logic              cmd_wr_acc;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_w;
    logic              res_zero;
    logic              res_neg;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin, cmd_use_acc, cmd_wr_acc,
        input  cmd_ready,
        input  res_valid, res_w, res_zero, res_neg,
        output res_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin, cmd_use_acc, cmd_wr_acc,
        output cmd_ready,
        output res_valid, res_w, res_zero, res_neg,
        input  res_ready
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// Sequencing stage in front of a combinational ALU. Commands are buffered in
// a DEPTH-entry FIFO, issued one at a time onto registered ALU inputs, held
// for SETTLE cycles, then the ALU result/flags are captured into a result
// register (and optionally the accumulator) and offered on a valid/ready port.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   bus (slave)      : command channel in, result channel out
//   alu_a/b/cin/op   : registered ALU operands, change only when a command issues
//   alu_w/zero/neg   : ALU result and flags
//   acc_q            : accumulator
//   busy             : FSM not idle or FIFO non-empty
module alu_issue_ctrl #(
    parameter int DATA_W = 16,
    parameter int OP_W   = 3,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst,
    alu_issue_ctrl_if.slave   bus,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_cin,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_w,
    input  logic              alu_zero,
    input  logic              alu_neg,
    output logic [DATA_W-1:0] acc_q,
    output logic              busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int EW = OP_W + 2 * DATA_W + 3;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [EW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic              wr_acc_q;
    logic              res_valid_q;
    logic [DATA_W-1:0] res_w_q;
    logic              res_zero_q;
    logic              res_neg_q;

    logic [OP_W-1:0]   head_op;
    logic [DATA_W-1:0] head_a;
    logic [DATA_W-1:0] head_b;
    logic              head_cin;
    logic              head_use_acc;
    logic              head_wr_acc;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    // Held low during reset so nothing is accepted until reset is released.
    assign bus.cmd_ready = !rst && !full;
    assign push          = bus.cmd_valid && bus.cmd_ready;

    // Issue from IDLE, or from HOLD on the same edge the result is taken.
    always_comb begin
        pop = 1'b0;
        if (!empty) begin
            if (state == IDLE)
                pop = 1'b1;
            else if (state == HOLD && bus.res_ready)
                pop = 1'b1;
        end
    end

    assign {head_op, head_a, head_b, head_cin, head_use_acc, head_wr_acc} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b,
                            bus.cmd_cin, bus.cmd_use_acc, bus.cmd_wr_acc};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            wr_acc_q    <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_cin     <= 1'b0;
            alu_op      <= '0;
            res_valid_q <= 1'b0;
            res_w_q     <= '0;
            res_zero_q  <= 1'b0;
            res_neg_q   <= 1'b0;
            acc_q       <= '0;
        end else begin
            // A is resolved here, so a use_acc command sees any accumulator
            // write made by the command before it.
            if (pop) begin
                alu_a    <= head_use_acc ? acc_q : head_a;
                alu_b    <= head_b;
                alu_cin  <= head_cin;
                alu_op   <= head_op;
                wr_acc_q <= head_wr_acc;
                cnt      <= CW'(SETTLE - 1);
            end
            case (state)
                IDLE: begin
                    if (pop)
                        state <= DRIVE;
                end
                DRIVE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        res_w_q     <= alu_w;
                        res_zero_q  <= alu_zero;
                        res_neg_q   <= alu_neg;
                        res_valid_q <= 1'b1;
                        if (wr_acc_q)
                            acc_q <= alu_w;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state       <= empty ? IDLE : DRIVE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_w     = res_w_q;
    assign bus.res_zero  = res_zero_q;
    assign bus.res_neg   = res_neg_q;
    assign busy          = (state != IDLE) || !empty;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU (op 0: A+B+cin).
// Expected results are computed in push order from a model accumulator and
// checked when the DUT's result handshake completes.
module tb_alu_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] alu_a, alu_b, alu_w, acc_q;
    logic        alu_cin, alu_zero, alu_neg, busy;
    logic [2:0]  alu_op;

    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.DATA_W(16), .OP_W(3)) bus ();

    alu_issue_ctrl #(.DATA_W(16), .OP_W(3), .DEPTH(4), .SETTLE(2)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_cin  (alu_cin),
        .alu_op   (alu_op),
        .alu_w    (alu_w),
        .alu_zero (alu_zero),
        .alu_neg  (alu_neg),
        .acc_q    (acc_q),
        .busy     (busy)
    );

    always_comb begin
        alu_w = alu_a ^ alu_b;
        if (alu_op == 3'd0)
            alu_w = alu_a + alu_b + {15'd0, alu_cin};
        alu_zero = (alu_w == 16'd0);
        alu_neg  = alu_w[15];
    end

    typedef struct packed {
        logic [15:0] w;
        logic        z;
        logic        n;
    } exp_t;

    exp_t        sb[$];
    int          hs_cyc[$];
    logic [15:0] m_acc;
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    bit          stall_chk = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst && bus.res_valid && bus.res_ready) begin
            if (sb.size() == 0) begin
                check_eq("stale_res", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("res_w", bus.res_w, e.w);
                check_eq("res_zero", bus.res_zero, e.z);
                check_eq("res_neg", bus.res_neg, e.n);
                hs_cyc.push_back(cyc);
            end
        end else if (!rst && stall_chk && bus.res_valid && !bus.res_ready && sb.size() > 0) begin
            check_eq("stall_w", bus.res_w, sb[0].w);
        end
    end

    task automatic model_push(input logic [15:0] a, input logic [15:0] b,
                              input logic cin, input logic ua, input logic wa);
        exp_t        e;
        logic [15:0] opa;
        opa = ua ? m_acc : a;
        e.w = opa + b + {15'd0, cin};
        e.z = (e.w == 16'd0);
        e.n = e.w[15];
        if (wa)
            m_acc = e.w;
        sb.push_back(e);
    endtask

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push_cmd(input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic ua, input logic wa);
        bit got = 1'b0;
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = 3'd0;
        bus.cmd_a       = a;
        bus.cmd_b       = b;
        bus.cmd_cin     = cin;
        bus.cmd_use_acc = ua;
        bus.cmd_wr_acc  = wa;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = bus.cmd_ready;
            @(posedge clk);
        end
        #1;
        bus.cmd_valid = 1'b0;
        if (got)
            model_push(a, b, cin, ua, wa);
        else
            check_eq("push_timeout", 0, 1);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && sb.size() > 0; i++)
            @(posedge clk);
        #1;
        if (sb.size() > 0)
            check_eq("drain_timeout", sb.size(), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("idle_busy", busy, 0);
        sync();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst             = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = '0;
        bus.cmd_a       = '0;
        bus.cmd_b       = '0;
        bus.cmd_cin     = 1'b0;
        bus.cmd_use_acc = 1'b0;
        bus.cmd_wr_acc  = 1'b0;
        bus.res_ready   = 1'b1;
        m_acc           = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cmd_ready", bus.cmd_ready, 0);
        check_eq("rst_res_valid", bus.res_valid, 0);
        check_eq("rst_acc", acc_q, 0);
        check_eq("rst_alu_a", alu_a, 0);
        check_eq("rst_res_w", bus.res_w, 0);
        check_eq("rst_busy", busy, 0);
        sync();
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", bus.cmd_ready, 1);
        sync();

        // 1: single command, latency of 3 cycles
        push_cmd(16'h0005, 16'h0003, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("t1_latency", bus.res_valid, (i == 3) ? 1 : 0);
        end
        check_eq("t1_alu_a", alu_a, 16'h0005);
        check_eq("t1_acc", acc_q, 16'h0009);
        sync();
        wait_drain();

        // 2: dependent accumulator chain, one result per 3 cycles
        hs_cyc.delete();
        push_cmd(16'h1234, 16'h0001, 1'b0, 1'b1, 1'b1);
        push_cmd(16'h4321, 16'h0001, 1'b0, 1'b1, 1'b1);
        wait_drain();
        check_eq("t2_count", hs_cyc.size(), 2);
        if (hs_cyc.size() == 2)
            check_eq("t2_spacing", hs_cyc[1] - hs_cyc[0], 3);
        check_eq("t2_acc", acc_q, 16'h000B);

        // 3: zero and negative flags, no accumulator write
        push_cmd(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        push_cmd(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        wait_drain();
        check_eq("t3_acc", acc_q, 16'h000B);

        // 4: stalled consumer, FIFO fills
        bus.res_ready = 1'b0;
        stall_chk     = 1'b1;
        push_cmd(16'h0100, 16'h0011, 1'b0, 1'b0, 1'b0);
        push_cmd(16'h0200, 16'h0022, 1'b1, 1'b0, 1'b0);
        push_cmd(16'h0300, 16'h0033, 1'b0, 1'b0, 1'b0);
        push_cmd(16'h0400, 16'h0044, 1'b1, 1'b0, 1'b0);
        push_cmd(16'h0500, 16'h0055, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("t4_full_ready", bus.cmd_ready, 0);
        check_eq("t4_busy", busy, 1);
        repeat (6) @(negedge clk);
        check_eq("t4_held_valid", bus.res_valid, 1);
        sync();
        stall_chk     = 1'b0;
        bus.res_ready = 1'b1;
        wait_drain();

        // 5: reset while in DRIVE with two queued
        push_cmd(16'h0A00, 16'h0001, 1'b0, 1'b0, 1'b1);
        push_cmd(16'h0B00, 16'h0002, 1'b0, 1'b0, 1'b1);
        push_cmd(16'h0C00, 16'h0003, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("t5_ready_in_rst", bus.cmd_ready, 0);
        sync();
        rst = 1'b0;
        sb.delete();
        m_acc = '0;
        @(negedge clk);
        check_eq("t5_res_valid", bus.res_valid, 0);
        check_eq("t5_acc", acc_q, 0);
        check_eq("t5_busy", busy, 0);
        check_eq("t5_ready", bus.cmd_ready, 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("t5_no_stale", bus.res_valid, 0);
        end
        sync();

        // 6: simultaneous push/pop with three queued
        bus.res_ready = 1'b0;
        push_cmd(16'h1000, 16'h0001, 1'b0, 1'b0, 1'b0);
        push_cmd(16'h2000, 16'h0002, 1'b0, 1'b0, 1'b0);
        push_cmd(16'h3000, 16'h0003, 1'b0, 1'b0, 1'b0);
        push_cmd(16'h4000, 16'h0004, 1'b0, 1'b1, 1'b1);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                seen = bus.res_valid;
            end
            check_eq("t6_hold_reached", seen, 1);
        end
        sync();
        bus.res_ready = 1'b1;
        push_cmd(16'h5000, 16'h0005, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check_eq("t6_simul_ready", bus.cmd_ready, 1);
        check_eq("t6_busy", busy, 1);
        sync();
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
